// File: rtl/thread_regfile_sb_pkg.sv
// Shared types for the per-thread register file.
//   core_state_t : core FSM state encoding (only REQUEST and UPDATE matter here)
//   reg_mux_t    : destination-write source select
//   RO_*         : offsets of the read-only special registers, counted down from NUM_REGS
package thread_regfile_sb_pkg;

  typedef enum logic [2:0] {
    CS_IDLE    = 3'b000,
    CS_FETCH   = 3'b001,
    CS_DECODE  = 3'b010,
    CS_REQUEST = 3'b011,
    CS_WAIT    = 3'b100,
    CS_EXECUTE = 3'b101,
    CS_UPDATE  = 3'b110,
    CS_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [1:0] {
    MUX_ALU      = 2'b00,
    MUX_MEMORY   = 2'b01,
    MUX_CONSTANT = 2'b10
  } reg_mux_t;

  // Special registers sit at NUM_REGS - offset.
  localparam int RO_BLOCK_IDX  = 3;
  localparam int RO_BLOCK_DIM  = 2;
  localparam int RO_THREAD_IDX = 1;

endpackage

// File: rtl/thread_regfile_sb_if.sv
// LSU load-writeback handshake.
//   valid/rd/data : driven by the LSU (master)
//   ready         : driven by the register file (slave); transfer when valid && ready
interface thread_regfile_sb_if #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8
);
  logic                 valid;
  logic [ADDR_BITS-1:0] rd;
  logic [DATA_BITS-1:0] data;
  logic                 ready;

  modport master (output valid, rd, data, input ready);
  modport slave  (input valid, rd, data, output ready);
endinterface

// File: rtl/thread_regfile_sb_scoreboard.sv
// Pending-bit scoreboard: one bit per register.
//   set_en/set_idx : mark a register pending (outstanding load)
//   clr_en/clr_idx : clear a pending bit (load written back)
//   lkp_*_idx/lkp_*: two combinational lookup ports
// A set and clear of the same bit in one cycle leaves it set.
module thread_regfile_sb_scoreboard #(
  parameter  int NUM_REGS  = 16,
  localparam int ADDR_BITS = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [ADDR_BITS-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [ADDR_BITS-1:0] clr_idx,
  input  logic [ADDR_BITS-1:0] lkp_a_idx,
  output logic                 lkp_a,
  input  logic [ADDR_BITS-1:0] lkp_b_idx,
  output logic                 lkp_b
);
  logic [NUM_REGS-1:0] pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (set_en && set_idx == ADDR_BITS'(i))      pend[i] <= 1'b1;
        else if (clr_en && clr_idx == ADDR_BITS'(i)) pend[i] <= 1'b0;
      end
    end
  end

  assign lkp_a = pend[lkp_a_idx];
  assign lkp_b = pend[lkp_b_idx];
endmodule

// File: rtl/thread_regfile_sb.sv
// Per-thread register file with load scoreboard.
//   clk, reset           : clock, synchronous active-high reset
//   enable               : lane active; low freezes all state and zeroes handshake/hazards
//   block_start/block_id : latch %blockIdx
//   core_state           : REQUEST reads rs/rt, UPDATE writes rd
//   rs/rt/rd_addr        : decoded register addresses
//   reg_we/reg_mux       : write enable and source (ALU, MEMORY, CONSTANT)
//   immediate/alu_out    : write data sources
//   wb                   : LSU writeback handshake (slave side)
//   rs/rt                : registered operands
//   raw_hazard           : a REQUEST operand is still pending
//   waw_hazard           : an UPDATE targets a pending rd; write suppressed
// The top three addresses are %blockIdx, %blockDim, %threadIdx and are read-only.
module thread_regfile_sb
  import thread_regfile_sb_pkg::*;
#(
  parameter  int DATA_BITS         = 8,
  parameter  int NUM_REGS          = 16,
  parameter  int THREADS_PER_BLOCK = 4,
  parameter  int THREAD_ID         = 0,
  localparam int ADDR_BITS         = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 block_start,
  input  logic [DATA_BITS-1:0] block_id,
  input  core_state_t          core_state,
  input  logic [ADDR_BITS-1:0] rs_addr,
  input  logic [ADDR_BITS-1:0] rt_addr,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 reg_we,
  input  reg_mux_t             reg_mux,
  input  logic [DATA_BITS-1:0] immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  thread_regfile_sb_if.slave   wb,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt,
  output logic                 raw_hazard,
  output logic                 waw_hazard
);
  localparam int NUM_WR = NUM_REGS - RO_BLOCK_IDX;
  localparam logic [ADDR_BITS-1:0] A_BLK_IDX = ADDR_BITS'(NUM_REGS - RO_BLOCK_IDX);
  localparam logic [ADDR_BITS-1:0] A_BLK_DIM = ADDR_BITS'(NUM_REGS - RO_BLOCK_DIM);
  localparam logic [ADDR_BITS-1:0] A_THR_IDX = ADDR_BITS'(NUM_REGS - RO_THREAD_IDX);
  localparam logic [DATA_BITS-1:0] BLK_DIM   = DATA_BITS'(THREADS_PER_BLOCK);
  localparam logic [DATA_BITS-1:0] THR_IDX   = DATA_BITS'(THREAD_ID);

  logic [NUM_WR-1:0][DATA_BITS-1:0]   file;
  logic [DATA_BITS-1:0]               blk_idx;
  logic [NUM_REGS-1:0][DATA_BITS-1:0] view;

  logic active, req, upd, rd_wr_ok, wb_wr_ok;
  logic pend_a, pend_b, alu_wr, mem_iss, wb_wr, byp_rs, byp_rt;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr, lkp_b_idx;
  logic [DATA_BITS-1:0] wr_data;

  assign active   = enable && !reset;
  assign req      = active && core_state == CS_REQUEST;
  assign upd      = active && core_state == CS_UPDATE && reg_we;
  assign rd_wr_ok = rd_addr < A_BLK_IDX;
  assign wb_wr_ok = wb.rd < A_BLK_IDX;

  // REQUEST and UPDATE never coincide, so the second lookup port
  // serves rt during REQUEST and rd during UPDATE.
  assign lkp_b_idx = (core_state == CS_UPDATE) ? rd_addr : rt_addr;

  assign waw_hazard = upd && rd_wr_ok && pend_b;
  assign alu_wr     = upd && reg_mux != MUX_MEMORY && rd_wr_ok && !waw_hazard;
  assign mem_iss    = upd && reg_mux == MUX_MEMORY && rd_wr_ok && !waw_hazard;

  // Single write port: an ALU/CONSTANT write stalls the LSU for one cycle.
  assign wb.ready = active && !alu_wr;
  assign wb_wr    = wb.valid && wb.ready && wb_wr_ok;

  // A load landing this cycle satisfies a pending operand directly.
  assign byp_rs     = wb_wr && wb.rd == rs_addr;
  assign byp_rt     = wb_wr && wb.rd == rt_addr;
  assign raw_hazard = req && ((pend_a && !byp_rs) || (pend_b && !byp_rt));

  assign wr_en   = alu_wr || wb_wr;
  assign wr_addr = alu_wr ? rd_addr : wb.rd;
  assign wr_data = alu_wr ? ((reg_mux == MUX_CONSTANT) ? immediate : alu_out) : wb.data;

  thread_regfile_sb_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en    (mem_iss),
    .set_idx   (rd_addr),
    .clr_en    (wb_wr),
    .clr_idx   (wb.rd),
    .lkp_a_idx (rs_addr),
    .lkp_a     (pend_a),
    .lkp_b_idx (lkp_b_idx),
    .lkp_b     (pend_b)
  );

  always_comb begin
    view = '0;
    for (int i = 0; i < NUM_WR; i++) view[i] = file[i];
    view[A_BLK_IDX] = blk_idx;
    view[A_BLK_DIM] = BLK_DIM;
    view[A_THR_IDX] = THR_IDX;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      file    <= '0;
      blk_idx <= '0;
      rs      <= '0;
      rt      <= '0;
    end else begin
      if (wr_en)
        for (int i = 0; i < NUM_WR; i++)
          if (wr_addr == ADDR_BITS'(i)) file[i] <= wr_data;
      if (active && block_start) blk_idx <= block_id;
      if (req && !raw_hazard) begin
        rs <= byp_rs ? wb.data : view[rs_addr];
        rt <= byp_rt ? wb.data : view[rt_addr];
      end
    end
  end
endmodule
